// File: rtl/cg_rvarch_regfile_mp.sv
// Multi-port RISC-V integer register file (x0 = 0) with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining CG_RVARCH_REGFILE_BYPASS_EN.

module cg_rvarch_regfile_mp_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_NUM   = 32,
`ifdef CG_RVARCH_REGFILE_BYPASS_EN
    parameter int NUM_WR     = 1,
`endif
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic [DATA_NUM-1:0][DATA_WIDTH-1:0]  regs,
    input  logic [DATA_NUM-1:0]                  busy,
`ifdef CG_RVARCH_REGFILE_BYPASS_EN
    input  logic                                 rst,
    input  logic [NUM_WR-1:0]                    wr_we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]         wr_data,
`endif
    output logic [DATA_WIDTH-1:0]                data,
    output logic                                 rs_busy
);
    always_comb begin
        data    = (addr == '0) ? '0 : regs[addr];
        rs_busy = (addr == '0) ? 1'b0 : busy[addr];
`ifdef CG_RVARCH_REGFILE_BYPASS_EN
        // Ascending scan so the highest-index matching write port wins.
        for (int j = 0; j < NUM_WR; j++) begin
            if (!rst && wr_we[j] && addr != '0 &&
                wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == addr) begin
                data    = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                rs_busy = 1'b0;
            end
        end
`endif
    end
endmodule

module cg_rvarch_regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_NUM   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    localparam int ADDR_WIDTH = $clog2(DATA_NUM)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]  i_rs_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]  o_rs_data,
    output logic [NUM_RD-1:0]             o_rs_busy,
    input  logic [NUM_WR-1:0]             i_rd_we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]  i_rd_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]  i_rd_data,
    input  logic                          i_busy_set,
    input  logic [ADDR_WIDTH-1:0]         i_busy_addr,
    output logic [DATA_NUM-1:0]           o_busy_vec
);
    logic [DATA_NUM-1:0][DATA_WIDTH-1:0] regs, regs_nxt;
    logic [DATA_NUM-1:0]                 busy, wr_hit, set_hit;

    always_comb begin
        regs_nxt = regs;
        wr_hit   = '0;
        set_hit  = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (i_rd_we[j] && i_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                regs_nxt[i_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = i_rd_data[j*DATA_WIDTH +: DATA_WIDTH];
                wr_hit[i_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]]   = 1'b1;
            end
        end
        if (i_busy_set && i_busy_addr != '0)
            set_hit[i_busy_addr] = 1'b1;
    end

    // A new issue to the same register outranks the writeback of the older producer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            regs <= regs_nxt;
            busy <= (busy & ~wr_hit) | set_hit;
        end
    end

    assign o_busy_vec = busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        cg_rvarch_regfile_mp_rd #(
            .DATA_WIDTH (DATA_WIDTH),
            .DATA_NUM   (DATA_NUM),
`ifdef CG_RVARCH_REGFILE_BYPASS_EN
            .NUM_WR     (NUM_WR),
`endif
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rd (
            .addr    (i_rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .regs    (regs),
            .busy    (busy),
`ifdef CG_RVARCH_REGFILE_BYPASS_EN
            .rst     (i_rst),
            .wr_we   (i_rd_we),
            .wr_addr (i_rd_addr),
            .wr_data (i_rd_data),
`endif
            .data    (o_rs_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .rs_busy (o_rs_busy[k])
        );
    end
endmodule
